pipe_issue: RTL and testbench
=============================

# pipe_issue

Instruction issue stage that sits directly upstream of the 4-stage register/ALU/memory pipeline and drives its rs1, rs2, rd, func and addr operand fields. It buffers packed 24-bit instruction words in a small FIFO and checks each head instruction against the rd fields of recently issued instructions. It issues one instruction per cycle, or a bubble when a read-after-write hazard exists. Illegal function codes are discarded and flagged.

## Interface
- DEPTH, 4: instruction FIFO entries (power of two, 2..16)
- HAZ_WIN, 1: number of most recent issue slots whose rd blocks a reader (1..3)
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction word offered
- in_ready  out  1  FIFO can accept (count < DEPTH)
- in_instr  in  24  {func[23:20], rd[19:16], rs1[15:12], rs2[11:8], addr[7:0]}
- iss_valid  out  1  issued fields are a real instruction (0 = bubble)
- rs1, rs2, rd, func  out  4 each  issued fields to pipeline stage 1
- addr  out  8  issued memory address
- illegal  out  1  one-cycle pulse: head with func > 11 dropped
- stall_cnt  out  16  bubbles inserted by hazards since reset, saturating
- issue_cnt  out  16  instructions issued since reset, wrapping

## Operation
- Push: in_valid & in_ready at an edge writes in_instr at the tail. in_ready is combinational from count only and is not widened by a same-cycle pop.
- Head evaluation each edge with FIFO non-empty:
  - func > 11: pop the head, pulse illegal, issue a bubble. This is not counted in stall_cnt.
  - Hazard: head rs1 or rs2 equals rd of any valid entry in the issue window (last HAZ_WIN slots). Do not pop. Issue a bubble and increment stall_cnt.
  - Otherwise: pop, load the output fields, set iss_valid = 1, increment issue_cnt.
- Empty FIFO: bubble, no counter change.
- Bubble: iss_valid = 0 and rs1/rs2/rd/func/addr hold their previous values. The pipeline gates on iss_valid.
- Issue window: shift register of {valid, rd}, shifted every cycle. It takes {1, rd} on an issue and {0, x} on a bubble, so hazards age out through bubbles.
- All func codes 0–11 write rd and are treated identically for hazard checks.
- rs1 == rs2 == the hazard register counts as a single stall, not two.
- An instruction with rs == rd of itself is not a hazard (self-reference reads the old value).

## Timing
- Reset (asynchronous assert, synchronous-clean deassert): FIFO empty, in_ready = 1, iss_valid = 0, all fields 0, illegal = 0, counters 0, window entries invalid.
- Latency: a word pushed at edge t issues at edge t+1 at the earliest, with outputs valid after that edge.
- Throughput: one issue per cycle when there are no hazards.
- A dependent instruction immediately behind its writer with HAZ_WIN = 1 gets exactly one bubble. With HAZ_WIN = n it gets n bubbles.
- Push into an empty FIFO and head evaluation in the same edge: the new word is not eligible until the next edge.
- Full FIFO and pop in the same cycle: no push, in_ready stays 0 for that cycle.
- Reset mid-stream discards FIFO contents and the window. No partial issue occurs.

## Structure
- Shared package pipe_pkg: the func code constants (ADD = 0 … SLL = 11, FUNC_MAX = 11), the instruction field positions, and a packed instr_t struct. These are also used by the pipeline and its bench.
- Sub-module issue_fifo (DEPTH × 24, count-based full/empty). Hazard logic and counters live in pipe_issue.

## Test plan
- Reset, then push {0,10,3,5,125}, {2,12,3,8,126}, {1,14,10,5,128}, {11,13,7,3,127} on consecutive cycles -> issues on 4 consecutive edges, no stall (rs1 = 10 is two slots after rd = 10), issue_cnt = 4.
- Push {0,10,3,5,0} then {1,14,10,5,0} back-to-back with HAZ_WIN = 1 -> valid, bubble, valid. stall_cnt = 1 and the second issue shows rs1 = 10.
- Same pair with HAZ_WIN = 3 -> exactly 3 bubbles between the issues, stall_cnt = 3.
- Push func = 13 between two legal words -> illegal pulses once, one bubble, issue_cnt counts only the 2 legal words, stall_cnt = 0.
- Fill 4 words while the head is stalled -> in_ready = 0 after the 4th push. A 5th in_valid is not accepted until a pop occurs.
- Assert rst_n = 0 mid-burst -> all outputs 0 and in_ready = 1 immediately. After release, no word from before the reset is issued.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the issue stage and the downstream pipeline:
// function codes, instruction field layout and the packed instruction word.
package pipe_pkg;

  localparam int INSTR_W = 24;

  localparam int FUNC_LSB = 20;
  localparam int RD_LSB   = 16;
  localparam int RS1_LSB  = 12;
  localparam int RS2_LSB  = 8;
  localparam int ADDR_LSB = 0;

  localparam logic [3:0] ADD      = 4'd0;
  localparam logic [3:0] SUB      = 4'd1;
  localparam logic [3:0] AND_OP   = 4'd2;
  localparam logic [3:0] OR_OP    = 4'd3;
  localparam logic [3:0] XOR_OP   = 4'd4;
  localparam logic [3:0] SLT      = 4'd5;
  localparam logic [3:0] LD       = 4'd6;
  localparam logic [3:0] ST       = 4'd7;
  localparam logic [3:0] MUL      = 4'd8;
  localparam logic [3:0] SRA      = 4'd9;
  localparam logic [3:0] SRL      = 4'd10;
  localparam logic [3:0] SLL      = 4'd11;
  localparam logic [3:0] FUNC_MAX = 4'd11;

  typedef struct packed {
    logic [3:0] func;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [7:0] addr;
  } instr_t;

  function automatic logic func_legal(input logic [3:0] func);
    return (func <= FUNC_MAX);
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// Instruction buffer for the issue stage: DEPTH x 24-bit circular FIFO with
// count-based full/empty; the head word is visible combinationally.
module issue_fifo
  import pipe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic       pop_i,
  input  instr_t     wdata_i,
  output instr_t     rdata_o,
  output logic [4:0] count_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  instr_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [4:0]      count_q;
  logic            push_ok_s;
  logic            pop_ok_s;

  assign full_o    = (count_q == 5'(DEPTH));
  assign empty_o   = (count_q == 5'd0);
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 5'd0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + 5'd1;
        2'b01:   count_q <= count_q - 5'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pipe_issue.sv
// Issue stage: buffers instruction words, blocks RAW hazards against the last
// HAZ_WIN issue slots and drives registered operand fields to the pipeline.
module pipe_issue
  import pipe_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int HAZ_WIN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_instr,
  output logic        iss_valid,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic [3:0]  rd,
  output logic [3:0]  func,
  output logic [7:0]  addr,
  output logic        illegal,
  output logic [15:0] stall_cnt,
  output logic [15:0] issue_cnt
);

  instr_t       head_s;
  logic [4:0]   fifo_count_s;
  logic         fifo_full_s;
  logic         fifo_empty_s;
  logic         push_s;
  logic         pop_s;
  logic         hazard_s;
  logic         issue_s;
  logic         drop_s;
  logic         stall_s;

  instr_t                    out_q;
  logic                      iss_valid_q;
  logic                      illegal_q;
  logic [15:0]               stall_cnt_q;
  logic [15:0]               issue_cnt_q;
  logic [HAZ_WIN-1:0]        win_v_q;
  logic [HAZ_WIN-1:0][3:0]   win_rd_q;

  assign in_ready = ~fifo_full_s;
  assign push_s   = in_valid & ~fifo_full_s;

  issue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (instr_t'(in_instr)),
    .rdata_o (head_s),
    .count_o (fifo_count_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // RAW check of the head sources against every valid rd in the issue window
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < HAZ_WIN; i++) begin
      hazard_s = hazard_s | (win_v_q[i] &
                 ((win_rd_q[i] == head_s.rs1) | (win_rd_q[i] == head_s.rs2)));
    end
  end

  // head disposition: drop illegal, hold on hazard, otherwise issue
  always_comb begin
    pop_s   = 1'b0;
    issue_s = 1'b0;
    drop_s  = 1'b0;
    stall_s = 1'b0;
    if (fifo_empty_s) begin
      pop_s = 1'b0;
    end else if (!func_legal(head_s.func)) begin
      pop_s  = 1'b1;
      drop_s = 1'b1;
    end else if (hazard_s) begin
      stall_s = 1'b1;
    end else begin
      pop_s   = 1'b1;
      issue_s = 1'b1;
    end
  end

  // registered outputs, counters and the issue-window shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      iss_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
      issue_cnt_q <= 16'd0;
      win_v_q     <= '0;
      win_rd_q    <= '0;
    end else begin
      iss_valid_q <= issue_s;
      illegal_q   <= drop_s;
      if (issue_s) begin
        out_q       <= head_s;
        issue_cnt_q <= issue_cnt_q + 16'd1;
      end
      if (stall_s && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      for (int i = HAZ_WIN - 1; i > 0; i--) begin
        win_v_q[i]  <= win_v_q[i-1];
        win_rd_q[i] <= win_rd_q[i-1];
      end
      win_v_q[0]  <= issue_s;
      win_rd_q[0] <= head_s.rd;
    end
  end

  assign iss_valid = iss_valid_q;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign rd        = out_q.rd;
  assign func      = out_q.func;
  assign addr      = out_q.addr;
  assign illegal   = illegal_q;
  assign stall_cnt = stall_cnt_q;
  assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_pipe_issue.sv
// Bench for pipe_issue: two instances (HAZ_WIN 1 and 3) compared every cycle
// against a list-based model, plus a vector table and directed corner cases.
module tb_pipe_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] in_instr = 24'd0;

  logic        a_ready, a_val, a_ill;
  logic [3:0]  a_rs1, a_rs2, a_rd, a_func;
  logic [7:0]  a_addr;
  logic [15:0] a_stall, a_issue;
  logic        b_ready, b_val, b_ill;
  logic [3:0]  b_rs1, b_rs2, b_rd, b_func;
  logic [7:0]  b_addr;
  logic [15:0] b_stall, b_issue;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_issue #(.DEPTH(4), .HAZ_WIN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ready),
    .in_instr(in_instr), .iss_valid(a_val), .rs1(a_rs1), .rs2(a_rs2),
    .rd(a_rd), .func(a_func), .addr(a_addr), .illegal(a_ill),
    .stall_cnt(a_stall), .issue_cnt(a_issue));

  pipe_issue #(.DEPTH(4), .HAZ_WIN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_ready),
    .in_instr(in_instr), .iss_valid(b_val), .rs1(b_rs1), .rs2(b_rs2),
    .rd(b_rd), .func(b_func), .addr(b_addr), .illegal(b_ill),
    .stall_cnt(b_stall), .issue_cnt(b_issue));

  // reference model: per instance an ordered list of waiting words and a
  // history of recent issue slots (rd of an issue, -1 for a bubble)
  int          haz [2] = '{1, 3};
  logic [23:0] mq [2][4];
  int          mcnt [2];
  int          hist [2][3];
  logic [23:0] mfield [2];
  logic        mval [2];
  logic        mill [2];
  int          mstall [2];
  int          missue [2];

  function automatic logic [23:0] w(input int f, input int d, input int r1,
                                    input int r2, input int a);
    return {4'(f), 4'(d), 4'(r1), 4'(r2), 8'(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0; mfield[k] = 24'd0; mval[k] = 1'b0; mill[k] = 1'b0;
      mstall[k] = 0; missue[k] = 0;
      for (int i = 0; i < 3; i++) hist[k][i] = -1;
    end
  endtask

  task automatic model_step(input int k);
    logic        accept;
    logic [23:0] h;
    int          newrd;
    logic        hz;
    accept  = in_valid && (mcnt[k] < 4);
    mval[k] = 1'b0;
    mill[k] = 1'b0;
    newrd   = -1;
    if (mcnt[k] > 0) begin
      h  = mq[k][0];
      hz = 1'b0;
      for (int i = 0; i < haz[k]; i++)
        if (hist[k][i] >= 0 && (hist[k][i] == int'(h[15:12]) || hist[k][i] == int'(h[11:8])))
          hz = 1'b1;
      if (int'(h[23:20]) > 11) begin
        mill[k] = 1'b1;
      end else if (hz) begin
        if (mstall[k] < 65535) mstall[k]++;
      end else begin
        mval[k] = 1'b1;
        mfield[k] = h;
        missue[k] = (missue[k] + 1) % 65536;
        newrd = int'(h[19:16]);
      end
      if (!hz || int'(h[23:20]) > 11) begin
        for (int i = 0; i < 3; i++) mq[k][i] = mq[k][i+1];
        mcnt[k]--;
      end
    end
    for (int i = 2; i > 0; i--) hist[k][i] = hist[k][i-1];
    hist[k][0] = newrd;
    if (accept) begin
      mq[k][mcnt[k]] = in_instr;
      mcnt[k]++;
    end
  endtask

  task automatic compare_all();
    chk("d1 iss_valid", 32'(a_val), 32'(mval[0]));
    chk("d1 fields", 32'({a_func, a_rd, a_rs1, a_rs2, a_addr}), 32'(mfield[0]));
    chk("d1 illegal", 32'(a_ill), 32'(mill[0]));
    chk("d1 stall_cnt", 32'(a_stall), 32'(mstall[0]));
    chk("d1 issue_cnt", 32'(a_issue), 32'(missue[0]));
    chk("d1 in_ready", 32'(a_ready), 32'(mcnt[0] < 4));
    chk("d3 iss_valid", 32'(b_val), 32'(mval[1]));
    chk("d3 fields", 32'({b_func, b_rd, b_rs1, b_rs2, b_addr}), 32'(mfield[1]));
    chk("d3 illegal", 32'(b_ill), 32'(mill[1]));
    chk("d3 stall_cnt", 32'(b_stall), 32'(mstall[1]));
    chk("d3 issue_cnt", 32'(b_issue), 32'(missue[1]));
    chk("d3 in_ready", 32'(b_ready), 32'(mcnt[1] < 4));
  endtask

  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " d1 outputs zero"},
        32'({a_val, a_ill, a_func, a_rd, a_rs1, a_rs2, a_addr}), 32'd0);
    chk({tag, " d1 counters zero"}, {a_stall, a_issue}, 32'd0);
    chk({tag, " d1 in_ready"}, 32'(a_ready), 32'd1);
    chk({tag, " d3 outputs zero"},
        32'({b_val, b_ill, b_func, b_rd, b_rs1, b_rs2, b_addr}), 32'd0);
    chk({tag, " d3 in_ready"}, 32'(b_ready), 32'd1);
  endtask

  typedef struct {
    logic        rst_before;
    logic        v;
    logic [23:0] instr;
    logic        e_val;
    logic [3:0]  e_rd;
    logic [3:0]  e_rs1;
    logic [15:0] e_stall;
    logic [15:0] e_issue;
  } vec_t;

  vec_t tv [11];
  int   iss_at [$];
  int   pulses;
  logic saw_full;

  initial begin
    // four independent words, then a writer/reader pair on the HAZ_WIN=1 instance
    tv[0]  = '{1'b1, 1'b1, w(0, 10, 3, 5, 125),  1'b0, 4'd0,  4'd0,  16'd0, 16'd0};
    tv[1]  = '{1'b0, 1'b1, w(2, 12, 3, 8, 126),  1'b1, 4'd10, 4'd3,  16'd0, 16'd1};
    tv[2]  = '{1'b0, 1'b1, w(1, 14, 10, 5, 128), 1'b1, 4'd12, 4'd3,  16'd0, 16'd2};
    tv[3]  = '{1'b0, 1'b1, w(11, 13, 7, 3, 127), 1'b1, 4'd14, 4'd10, 16'd0, 16'd3};
    tv[4]  = '{1'b0, 1'b0, 24'd0,                1'b1, 4'd13, 4'd7,  16'd0, 16'd4};
    tv[5]  = '{1'b0, 1'b0, 24'd0,                1'b0, 4'd13, 4'd7,  16'd0, 16'd4};
    tv[6]  = '{1'b1, 1'b1, w(0, 10, 3, 5, 0),    1'b0, 4'd0,  4'd0,  16'd0, 16'd0};
    tv[7]  = '{1'b0, 1'b1, w(1, 14, 10, 5, 0),   1'b1, 4'd10, 4'd3,  16'd0, 16'd1};
    tv[8]  = '{1'b0, 1'b0, 24'd0,                1'b0, 4'd10, 4'd3,  16'd1, 16'd1};
    tv[9]  = '{1'b0, 1'b0, 24'd0,                1'b1, 4'd14, 4'd10, 16'd1, 16'd2};
    tv[10] = '{1'b0, 1'b0, 24'd0,                1'b0, 4'd14, 4'd10, 16'd1, 16'd2};

    model_reset();
    do_reset();
    chk_zero("reset");

    for (int i = 0; i < 11; i++) begin
      if (tv[i].rst_before) do_reset();
      in_valid = tv[i].v;
      in_instr = tv[i].instr;
      cycle();
      chk("tv iss_valid", 32'(a_val), 32'(tv[i].e_val));
      chk("tv rd", 32'(a_rd), 32'(tv[i].e_rd));
      chk("tv rs1", 32'(a_rs1), 32'(tv[i].e_rs1));
      chk("tv stall_cnt", 32'(a_stall), 32'(tv[i].e_stall));
      chk("tv issue_cnt", 32'(a_issue), 32'(tv[i].e_issue));
    end

    // HAZ_WIN=3: exactly three bubbles between writer and dependent reader
    do_reset();
    iss_at.delete();
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 2);
      in_instr = (c == 0) ? w(0, 10, 3, 5, 0) : w(1, 14, 10, 5, 0);
      cycle();
      if (b_val) iss_at.push_back(c);
    end
    chk("win3 issue count", 32'(iss_at.size()), 32'd2);
    if (iss_at.size() == 2) chk("win3 bubbles", 32'(iss_at[1] - iss_at[0] - 1), 32'd3);
    chk("win3 stall_cnt", 32'(b_stall), 32'd3);

    // illegal word between two legal words
    do_reset();
    pulses = 0;
    for (int c = 0; c < 7; c++) begin
      in_valid = (c < 3);
      in_instr = (c == 0) ? w(0, 1, 2, 3, 9) : (c == 1) ? w(13, 4, 4, 4, 9) : w(3, 4, 5, 6, 9);
      cycle();
      if (a_ill) pulses++;
    end
    chk("illegal pulses", 32'(pulses), 32'd1);
    chk("illegal issue_cnt", 32'(a_issue), 32'd2);
    chk("illegal stall_cnt", 32'(a_stall), 32'd0);

    // fill behind a dependency chain until in_ready drops, then keep offering
    do_reset();
    saw_full = 1'b0;
    for (int c = 0; c < 20 && !saw_full; c++) begin
      in_valid = 1'b1;
      in_instr = w(0, (c + 1) % 16, c % 16, c % 16, c);
      cycle();
      if (!a_ready) saw_full = 1'b1;
    end
    chk("fill in_ready low", 32'(saw_full), 32'd1);
    in_instr = w(5, 9, 9, 9, 99);
    repeat (6) cycle();
    in_valid = 1'b0;
    repeat (10) cycle();

    // asynchronous reset mid-burst
    do_reset();
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_instr = w(1, c + 2, 0, 1, c);
      cycle();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero("midreset");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) cycle();

    // randomized traffic with a small register range to provoke hazards
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_instr = w(($urandom_range(0, 7) == 0) ? $urandom_range(12, 15) : $urandom_range(0, 11),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 255));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
